// File: rtl/rr_share_arbiter9_if.sv
// Handshake bundle between nine producers, the arbiter and one consumer.
// The arbiter takes the slave view; the producer/consumer side takes master.
interface rr_share_arbiter9_if;
  logic [8:0]   req;
  logic [143:0] data_in;
  logic [8:0]   ack;
  logic [8:0]   gnt;
  logic [3:0]   sel;
  logic         out_valid;
  logic [15:0]  out_data;
  logic         out_ready;

  modport slave (
    input  req, data_in, out_ready,
    output ack, gnt, sel, out_valid, out_data
  );

  modport master (
    output req, data_in, out_ready,
    input  ack, gnt, sel, out_valid, out_data
  );
endinterface

// File: rtl/rr_share_arbiter9.sv
// Round-robin arbiter sharing one 16-bit valid/ready channel among nine
// requesters. Each grant is capped at BURST accepted words, and one IDLE
// cycle always separates consecutive grants.
//
// state | meaning
// IDLE  | no owner; sel=4'hF, gnt=0; picks next requester from ptr
// GRANT | sel owns the channel until BURST transfers or req withdrawal
module rr_share_arbiter9 #(
  parameter int BURST = 4
) (
  input  logic clk,
  input  logic reset,
  rr_share_arbiter9_if.slave bus
);

  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [8:0]    gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          found;
  logic [3:0]    pick;
  logic          req_sel;
  logic [15:0]   word_sel;
  logic          valid;
  logic          xfer;
  int            idx;

  // Cyclic priority scan starting at ptr: first pending requester wins.
  always_comb begin
    found = 1'b0;
    pick  = 4'd0;
    idx   = 0;
    for (int i = 0; i < 9; i++) begin
      idx = int'(ptr_q) + i;
      if (idx > 8) idx = idx - 9;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = 4'(idx);
      end
    end
  end

  // Nine-to-one selection of the owner's request bit and data word.
  always_comb begin
    req_sel  = 1'b0;
    word_sel = 16'hFFFF;
    for (int k = 0; k < 9; k++) begin
      if (sel_q == 4'(k)) begin
        req_sel  = bus.req[k];
        word_sel = bus.data_in[k*16 +: 16];
      end
    end
  end

  // Output handshake; suppressed during reset so no word is accepted then.
  always_comb begin
    valid         = (state_q == GRANT) && req_sel && !reset;
    xfer          = valid && bus.out_ready;
    bus.out_valid = valid;
    bus.out_data  = valid ? word_sel : 16'hFFFF;
    bus.ack       = xfer ? gnt_q : 9'd0;
    bus.sel       = sel_q;
    bus.gnt       = gnt_q;
  end

  // Next-state logic: grant on request, release on burst end or withdrawal.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          gnt_d   = 9'b1 << pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req_sel || (xfer && cnt_q == CW'(BURST - 1))) begin
          ptr_d   = (sel_q == 4'd8) ? 4'd0 : sel_q + 4'd1;
          cnt_d   = '0;
          sel_d   = 4'hF;
          gnt_d   = 9'd0;
          state_d = IDLE;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        sel_d   = 4'hF;
        gnt_d   = 9'd0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 4'hF;
      gnt_q   <= 9'd0;
      ptr_q   <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
